// File: rtl/rf_access_ctrl.sv
// Operand-fetch controller: reads two source registers from a registered-read
// register file and forwards in-flight write-backs so the operands never go stale.
module rf_access_ctrl #(
    parameter int addr_width = 4,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [addr_width-1:0] rs_a,
    input  logic [addr_width-1:0] rs_b,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [data_width-1:0] op_a,
    output logic [data_width-1:0] op_b,
    input  logic                  wb_valid,
    input  logic [addr_width-1:0] wb_addr,
    input  logic [data_width-1:0] wb_data,
    output logic                  rf_we,
    output logic [addr_width-1:0] rf_wadr,
    output logic [data_width-1:0] rf_din,
    output logic [addr_width-1:0] rf_radr,
    input  logic [data_width-1:0] rf_dout
);

    typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, CAP_B, DONE} state_t;

    state_t                state, next_state;
    logic [addr_width-1:0] rs_a_q, rs_b_q;
    logic                  fwd_a, fwd_b;
    logic                  accept, in_flight, hit_a, hit_b;

    assign rf_we   = wb_valid & ~reset;
    assign rf_wadr = wb_addr;
    assign rf_din  = wb_data;

    assign accept    = req_valid & req_ready;
    assign in_flight = (state != IDLE);
    assign hit_a     = wb_valid & in_flight & (wb_addr == rs_a_q);
    assign hit_b     = wb_valid & in_flight & (wb_addr == rs_b_q);

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        op_valid   = 1'b0;
        rf_radr    = rs_b_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = ISSUE_A;
            end
            ISSUE_A: begin
                rf_radr    = rs_a_q;
                next_state = ISSUE_B;
            end
            ISSUE_B: next_state = CAP_B;
            CAP_B:   next_state = DONE;
            DONE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    req_ready  = 1'b1;
                    next_state = req_valid ? ISSUE_A : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            req_ready = 1'b0;
            op_valid  = 1'b0;
        end
    end

    // A write-back to a latched source always beats the register-file capture,
    // whether it lands earlier in the sequence (fwd flag) or on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rs_a_q <= '0;
            rs_b_q <= '0;
            op_a   <= '0;
            op_b   <= '0;
            fwd_a  <= 1'b0;
            fwd_b  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                rs_a_q <= rs_a;
                rs_b_q <= rs_b;
                fwd_a  <= 1'b0;
                fwd_b  <= 1'b0;
            end else begin
                if (hit_a) fwd_a <= 1'b1;
                if (hit_b) fwd_b <= 1'b1;
            end
            if (hit_a)
                op_a <= wb_data;
            else if (state == ISSUE_B && !fwd_a)
                op_a <= rf_dout;
            if (hit_b)
                op_b <= wb_data;
            else if (state == CAP_B && !fwd_b)
                op_b <= rf_dout;
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: directed scenarios plus random traffic, checked
// against a request/latency model and a reference copy of the register file.
module tb_rf_access_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [AW-1:0] rs_a = '0, rs_b = '0;
    logic          op_valid, op_ready = 1'b0;
    logic [DW-1:0] op_a, op_b;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_wadr, rf_radr;
    logic [DW-1:0] rf_din, rf_dout = '0;

    always #5 clk = ~clk;

    rf_access_ctrl #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs_a(rs_a), .rs_b(rs_b),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_din(rf_din),
        .rf_radr(rf_radr), .rf_dout(rf_dout)
    );

    // Register file with one-cycle registered read, read-before-write on the same edge.
    logic [DW-1:0] regFile [16];
    always @(posedge clk) begin
        if (rf_we) regFile[rf_wadr] <= rf_din;
        rf_dout <= regFile[rf_radr];
    end

    logic [DW-1:0] refMem [16];
    bit            busy = 1'b0;
    bit            zeroOps = 1'b0;
    int            age = 0;
    logic [AW-1:0] refA = '0, refB = '0;
    int            vectors = 0;
    int            miscompares = 0;
    logic          snapValid, snapReady;
    logic [DW-1:0] snapOpA, snapOpB;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge.
    task automatic applyStimulus(input bit rst, input bit rv, input logic [AW-1:0] ra,
                                 input logic [AW-1:0] rb, input bit ordy, input bit wv,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit expValid, expReady;
        @(negedge clk);
        reset = rst; req_valid = rv; rs_a = ra; rs_b = rb; op_ready = ordy;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        #1;
        expValid = !rst && busy && age >= 3;
        expReady = !rst && (!busy || (expValid && ordy));
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("op_valid", 32'(op_valid), 32'(expValid));
        checkOutput("rf_we", 32'(rf_we), 32'(wv && !rst));
        if (wv) begin
            checkOutput("rf_wadr", 32'(rf_wadr), 32'(wa));
            checkOutput("rf_din", 32'(rf_din), 32'(wd));
        end
        if (expValid) begin
            checkOutput("op_a", 32'(op_a), 32'(refMem[refA]));
            checkOutput("op_b", 32'(op_b), 32'(refMem[refB]));
        end else if (!rst && zeroOps && !busy) begin
            checkOutput("op_a_cleared", 32'(op_a), 32'h0);
            checkOutput("op_b_cleared", 32'(op_b), 32'h0);
        end
        snapValid = op_valid; snapReady = req_ready; snapOpA = op_a; snapOpB = op_b;
        @(posedge clk);
        if (rst) begin
            busy = 1'b0;
            zeroOps = 1'b1;
        end else if (rv && expReady) begin
            busy = 1'b1; age = 0; refA = ra; refB = rb; zeroOps = 1'b0;
        end else if (expValid && ordy) begin
            busy = 1'b0;
        end else if (busy && age < 3) begin
            age++;
        end
        if (wv && !rst) refMem[wa] = wd;
    endtask

    task automatic idleCycle(input bit ordy);
        applyStimulus(1'b0, 1'b0, '0, '0, ordy, 1'b0, '0, '0);
    endtask

    initial begin
        bit            rst, rv, ordy, wv;
        logic [AW-1:0] ra, rb, wa;
        logic [DW-1:0] wd;
        for (int i = 0; i < 16; i++) begin
            regFile[i] = '0;
            refMem[i]  = '0;
        end

        applyStimulus(1'b1, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd9, 16'h1111);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        idleCycle(1'b0);

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd3, 16'h1234);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd7, 16'hBEEF);

        // Plain fetch of r3/r7.
        applyStimulus(1'b0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, '0, '0);
        repeat (3) idleCycle(1'b0);
        idleCycle(1'b0);
        checkOutput("fetch_valid", 32'(snapValid), 32'h1);
        checkOutput("fetch_op_a", 32'(snapOpA), 32'h1234);
        checkOutput("fetch_op_b", 32'(snapOpB), 32'hBEEF);
        idleCycle(1'b1);

        // Write to r3 in ISSUE_A while fetching r3 twice.
        applyStimulus(1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd3, 16'h5555);
        repeat (2) idleCycle(1'b0);
        idleCycle(1'b0);
        checkOutput("fwd_issue_op_a", 32'(snapOpA), 32'h5555);
        checkOutput("fwd_issue_op_b", 32'(snapOpB), 32'h5555);
        idleCycle(1'b1);

        // Write to r7 while DONE is stalled.
        applyStimulus(1'b0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, '0, '0);
        repeat (3) idleCycle(1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd7, 16'h0A0A);
        idleCycle(1'b1);
        checkOutput("fwd_done_valid", 32'(snapValid), 32'h1);
        checkOutput("fwd_done_op_b", 32'(snapOpB), 32'h0A0A);

        // Back-to-back acceptance out of DONE.
        applyStimulus(1'b0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, '0, '0);
        repeat (3) idleCycle(1'b0);
        applyStimulus(1'b0, 1'b1, 4'd7, 4'd3, 1'b1, 1'b0, '0, '0);
        checkOutput("b2b_ready", 32'(snapReady), 32'h1);
        idleCycle(1'b0);
        checkOutput("b2b_gap_valid", 32'(snapValid), 32'h0);
        repeat (2) idleCycle(1'b0);
        idleCycle(1'b1);
        checkOutput("b2b_op_a", 32'(snapOpA), 32'h0A0A);
        checkOutput("b2b_op_b", 32'(snapOpB), 32'h5555);

        // Reset in CAP_B, then a request whose acceptance cycle writes r5.
        applyStimulus(1'b0, 1'b1, 4'd3, 4'd7, 1'b0, 1'b0, '0, '0);
        repeat (2) idleCycle(1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 4'd5, 4'd3, 1'b0, 1'b1, 4'd5, 16'h0001);
        checkOutput("rst_valid", 32'(snapValid), 32'h0);
        checkOutput("rst_op_a", 32'(snapOpA), 32'h0);
        checkOutput("rst_op_b", 32'(snapOpB), 32'h0);
        repeat (3) idleCycle(1'b0);
        idleCycle(1'b1);
        checkOutput("idle_wr_op_a", 32'(snapOpA), 32'h0001);
        checkOutput("idle_wr_op_b", 32'(snapOpB), 32'h5555);

        // Random traffic with addresses biased toward collisions.
        for (int n = 0; n < 2500; n++) begin
            rst  = ($urandom_range(0, 59) == 0);
            rv   = 1'($urandom_range(0, 1));
            ra   = 4'($urandom_range(0, 3));
            rb   = 4'($urandom_range(0, 3));
            ordy = ($urandom_range(0, 2) != 0);
            wv   = ($urandom_range(0, 4) < 2);
            case ($urandom_range(0, 2))
                0:       wa = refA;
                1:       wa = refB;
                default: wa = 4'($urandom_range(0, 15));
            endcase
            wd = 16'($urandom);
            applyStimulus(rst, rv, ra, rb, ordy, wv, wa, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
